// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader:
// FSM state encodings, header sizes and an accepting-state helper.
package boot_pkg;

  localparam int PC_BYTES       = 4;
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [2:0] HDR_PC  = 3'd0;
  localparam logic [2:0] HDR_LEN = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] CSUM    = 3'd3;
  localparam logic [2:0] HOLD    = 3'd4;
  localparam logic [2:0] RUN     = 3'd5;
  localparam logic [2:0] ERROR   = 3'd6;

  // States in which the byte stream is drained.
  function automatic logic accepts(input logic [2:0] s);
    return s == HDR_PC || s == HDR_LEN || s == LOAD ||
           s == CSUM   || s == ERROR;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bus bundles for the boot loader.
// boot_stream_if: byte stream (in_data, in_valid, in_ready).
// imem_wr_if: instruction-memory write port (im_we, im_addr, im_wdata).
interface boot_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 6
);
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (output im_we, output im_addr, output im_wdata);
  modport slave  (input  im_we, input  im_addr, input  im_wdata);
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// 8-to-32 big-endian packer with a 2-bit byte counter.
// Ports: clk, rst_n (sync, active-low), clr_i, push_i, byte_i,
//        cnt_o, word_o (current bytes + byte_i), word_valid_o.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [1:0]  cnt_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] sr_q;
  logic [1:0]  cnt_q;

  // Word is presented in the same cycle its last byte arrives.
  assign word_o       = {sr_q, byte_i};
  assign word_valid_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign cnt_o        = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (push_i) begin
      sr_q  <= word_o[23:0];
      cnt_q <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a big-endian image (PC, count, words) into
// instruction memory, then releases the processor from reset.
// Ports: CLK, Reset_L (sync, active-low), src (byte stream slave),
//        reload, imem (write master), proc_reset_l, start_pc, done, err.
// Build option: define BOOT_CSUM_EN for a trailing XOR checksum byte.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH  = 64,
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         CLK,
  input  logic         Reset_L,
  boot_stream_if.slave src,
  input  logic         reload,
  imem_wr_if.master    imem,
  output logic         proc_reset_l,
  output logic [31:0]  start_pc,
  output logic         done,
  output logic         err
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

`ifdef BOOT_CSUM_EN
  localparam logic [2:0] POST_LOAD = CSUM;
`else
  localparam logic [2:0] POST_LOAD = HOLD;
`endif

  logic [2:0]        state_q, state_d;
  logic              rdy_q, rdy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              prst_q, prst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef BOOT_CSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        fire;
  logic        pk_push;
  logic        pk_clr;
  logic [1:0]  pk_cnt;
  logic [31:0] pk_word;
  logic        pk_wv;
  logic [15:0] n16;

  assign fire    = src.in_valid && rdy_q;
  assign pk_push = fire &&
    (state_q == HDR_PC || state_q == HDR_LEN || state_q == LOAD);
  assign n16     = pk_word[15:0];

  byte_packer u_pk (
    .clk          (CLK),
    .rst_n        (Reset_L),
    .clr_i        (pk_clr),
    .push_i       (pk_push),
    .byte_i       (src.in_data),
    .cnt_o        (pk_cnt),
    .word_o       (pk_word),
    .word_valid_o (pk_wv)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    widx_d  = widx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    prst_d  = prst_q;
    done_d  = done_q;
    pk_clr  = 1'b0;
`ifdef BOOT_CSUM_EN
    xor_d   = xor_q;
`endif
    unique case (state_q)
      HDR_PC: begin
        if (fire && pk_cnt == 2'(PC_BYTES - 1)) begin
          pc_d    = pk_word;
          state_d = HDR_LEN;
        end
      end
      HDR_LEN: begin
        if (fire && pk_cnt == 2'(LEN_BYTES - 1)) begin
          pk_clr = 1'b1;
          widx_d = '0;
          hold_d = '0;
`ifdef BOOT_CSUM_EN
          xor_d  = '0;
`endif
          if (n16 > 16'(IMEM_DEPTH)) begin
            state_d = ERROR;
          end else if (n16 == 16'd0) begin
            state_d = POST_LOAD;
          end else begin
            len_d   = n16[ADDR_W:0];
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
`ifdef BOOT_CSUM_EN
        if (fire) xor_d = xor_q ^ src.in_data;
`endif
        if (pk_wv) begin
          we_d    = 1'b1;
          wdata_d = pk_word;
          addr_d  = widx_q[ADDR_W-1:0];
          widx_d  = widx_q + 1'b1;
          if (widx_q == len_q - 1'b1) state_d = POST_LOAD;
        end
      end
`ifdef BOOT_CSUM_EN
      CSUM: begin
        if (fire) state_d = (src.in_data == xor_q) ? HOLD : ERROR;
      end
`endif
      HOLD: begin
        // The trailing write cycle is not part of the hold window.
        if (!we_q) begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            prst_d  = 1'b1;
            done_d  = 1'b1;
            state_d = RUN;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (reload) begin
          prst_d  = 1'b0;
          done_d  = 1'b0;
          pk_clr  = 1'b1;
          state_d = HDR_PC;
        end
      end
      ERROR: begin
        prst_d = 1'b0;
      end
      default: begin
        state_d = HDR_PC;
      end
    endcase
    err_d = (state_d == ERROR);
    rdy_d = accepts(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q <= HDR_PC;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      len_q   <= '0;
      widx_q  <= '0;
      hold_q  <= '0;
      prst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BOOT_CSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
      hold_q  <= hold_d;
      prst_q  <= prst_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef BOOT_CSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign src.in_ready  = rdy_q;
  assign imem.im_we    = we_q;
  assign imem.im_addr  = addr_q;
  assign imem.im_wdata = wdata_q;
  assign proc_reset_l  = prst_q;
  assign start_pc      = pc_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader.
// Honours BOOT_CSUM_EN by appending the checksum byte.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        reload;
  logic        prst;
  logic        done;
  logic        err;
  logic [31:0] spc;

  always #5 clk = ~clk;

  boot_stream_if src ();
  imem_wr_if #(.ADDR_W(6)) imem ();

  imem_boot_loader #(
    .IMEM_DEPTH  (64),
    .ADDR_W      (6),
    .HOLD_CYCLES (4)
  ) dut (
    .CLK          (clk),
    .Reset_L      (rst_l),
    .src          (src),
    .reload       (reload),
    .imem         (imem),
    .proc_reset_l (prst),
    .start_pc     (spc),
    .done         (done),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_acc = 0;
  int rise_cyc = -1;
  logic prst_prev = 1'b0;
  logic [7:0]  csum_flip = 8'h00;
  logic [5:0]  wa[$];
  logic [31:0] wd[$];
  int          wc[$];
  logic [31:0] img_w[$];

  always @(negedge clk) begin
    cyc++;
    if (imem.im_we) begin
      wa.push_back(imem.im_addr);
      wd.push_back(imem.im_wdata);
      wc.push_back(cyc);
    end
    if (prst && !prst_prev) rise_cyc = cyc;
    prst_prev = prst;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
    wc.delete();
    rise_cyc = -1;
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", {31'd0, src.in_ready}, 32'd0);
    chk("rst_im_we", {31'd0, imem.im_we}, 32'd0);
    chk("rst_im_addr", {26'd0, imem.im_addr}, 32'd0);
    chk("rst_im_wdata", imem.im_wdata, 32'd0);
    chk("rst_proc_reset_l", {31'd0, prst}, 32'd0);
    chk("rst_start_pc", spc, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    src.in_data  = b;
    src.in_valid = 1'b1;
    @(negedge clk);
    while (!src.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!src.in_ready) chk("ready_wait", {31'd0, src.in_ready}, 32'd1);
    @(posedge clk);
    last_acc = cyc + 1;
    #1;
    src.in_valid = 1'b0;
    src.in_data  = 8'h00;
  endtask

  task automatic send_g(input logic [7:0] b, input bit gappy);
    if (gappy && $urandom_range(0, 1) == 1) begin
      @(posedge clk);
      #1;
    end
    send_byte(b);
  endtask

  task automatic send_img(input logic [31:0] pc, input logic [15:0] n,
                          input bit gappy);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 3; i >= 0; i--) send_g(pc[8*i +: 8], gappy);
    send_g(n[15:8], gappy);
    send_g(n[7:0], gappy);
    foreach (img_w[j]) begin
      for (int i = 3; i >= 0; i--) begin
        send_g(img_w[j][8*i +: 8], gappy);
        x = x ^ img_w[j][8*i +: 8];
      end
    end
`ifdef BOOT_CSUM_EN
    send_g(x ^ csum_flip, gappy);
`else
    if (x === 8'hxx) $display("note: unknown image byte");
`endif
  endtask

  task automatic wait_rel();
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("release_wait", {31'd0, done}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Release comes HOLD_CYCLES cycles after the write cycle or after
  // the last accepted byte when no write trails it.
  task automatic chk_rel(input bit from_byte);
`ifdef BOOT_CSUM_EN
    from_byte = 1'b1;
`endif
    if (from_byte)
      chk("hold_after_byte", 32'(rise_cyc - last_acc), 32'd4);
    else
      chk("hold_after_write", 32'(rise_cyc - wc[$]), 32'd5);
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
  endtask

  initial begin
    rst_l        = 1'b0;
    reload       = 1'b0;
    src.in_valid = 1'b0;
    src.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Two words at full rate
    clr_log();
    img_w = '{32'h20010005, 32'h00000000};
    send_img(32'h00000000, 16'd2, 1'b0);
    wait_rel();
    chk("t1_nwr", 32'(wa.size()), 32'd2);
    chk("t1_a0", {26'd0, wa[0]}, 32'd0);
    chk("t1_d0", wd[0], 32'h20010005);
    chk("t1_a1", {26'd0, wa[1]}, 32'd1);
    chk("t1_d1", wd[1], 32'h00000000);
    chk("t1_wr_gap", 32'(wc[1] - wc[0]), 32'd4);
    chk_rel(1'b0);
    chk("t1_prst", {31'd0, prst}, 32'd1);
    chk("t1_pc", spc, 32'h0);
    chk("t1_rdy", {31'd0, src.in_ready}, 32'd0);

    // Reload from RUN
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    @(negedge clk);
    chk("t5_prst_drop", {31'd0, prst}, 32'd0);
    chk("t5_done_drop", {31'd0, done}, 32'd0);
    chk("t5_old_pc", spc, 32'h0);
    chk("t5_rdy", {31'd0, src.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    clr_log();
    img_w = '{32'hDEADBEEF};
    send_img(32'h00000040, 16'd1, 1'b0);
    wait_rel();
    chk("t5_nwr", 32'(wa.size()), 32'd1);
    chk("t5_a0", {26'd0, wa[0]}, 32'd0);
    chk("t5_d0", wd[0], 32'hDEADBEEF);
    chk("t5_pc", spc, 32'h40);
    chk("t5_prst", {31'd0, prst}, 32'd1);
    chk_rel(1'b0);

    // Empty image
    do_reset();
    clr_log();
    img_w.delete();
    send_img(32'h00000100, 16'd0, 1'b0);
    wait_rel();
    chk("t3_nwr", 32'(wa.size()), 32'd0);
    chk("t3_pc", spc, 32'h100);
    chk_rel(1'b1);

    // Gapped stream, three words
    do_reset();
    clr_log();
    img_w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    send_img(32'h00000008, 16'd3, 1'b1);
    wait_rel();
    chk("t4_nwr", 32'(wa.size()), 32'd3);
    chk("t4_a2", {26'd0, wa[2]}, 32'd2);
    chk("t4_d0", wd[0], 32'h11223344);
    chk("t4_d1", wd[1], 32'h55667788);
    chk("t4_d2", wd[2], 32'h99AABBCC);
    chk("t4_pc", spc, 32'h8);
    chk_rel(1'b0);

    // Oversized count
    do_reset();
    clr_log();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h41);
    @(negedge clk);
    chk("t2_err", {31'd0, err}, 32'd1);
    chk("t2_prst", {31'd0, prst}, 32'd0);
    chk("t2_rdy", {31'd0, src.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i));
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t2_err_hold", {31'd0, err}, 32'd1);
    chk("t2_prst_hold", {31'd0, prst}, 32'd0);
    chk("t2_done", {31'd0, done}, 32'd0);
    chk("t2_nwr", 32'(wa.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-load after five data bytes
    do_reset();
    clr_log();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    rst_l = 1'b0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    @(negedge clk);
    chk_reset();
    chk("t6_partial_nwr", 32'(wa.size()), 32'd1);
    @(posedge clk);
    #1;
    clr_log();
    img_w = '{32'hA5A5A5A5, 32'h5A5A5A5A};
    send_img(32'h00000020, 16'd2, 1'b0);
    wait_rel();
    chk("t6_nwr", 32'(wa.size()), 32'd2);
    chk("t6_d1", wd[1], 32'h5A5A5A5A);
    chk("t6_a1", {26'd0, wa[1]}, 32'd1);
    chk("t6_pc", spc, 32'h20);
    chk("t6_done", {31'd0, done}, 32'd1);

`ifdef BOOT_CSUM_EN
    // Bad checksum
    do_reset();
    clr_log();
    img_w = '{32'h0F0F0F0F};
    csum_flip = 8'hFF;
    send_img(32'h0, 16'd1, 1'b0);
    csum_flip = 8'h00;
    @(negedge clk);
    chk("cs_err", {31'd0, err}, 32'd1);
    chk("cs_prst", {31'd0, prst}, 32'd0);
    chk("cs_nwr", 32'(wa.size()), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
